game_board_ctrl: RTL and testbench
==================================

Name: game_board_ctrl

Overview:
- Writer side of the tic-tac-toe board: accepts player moves, writes the nine 2-bit cell registers and alternates turns.
- Drives the cell values consumed by the combinational outcome checker, samples the checker's result one cycle after each write, and latches game-over state.
- Owns the move counter and forces TIE after 9 legal moves with no winner.

Parameters:
- START_PLAYER, 2'b01, player holding the first turn after reset/new_game (2'b01 = P1, 2'b10 = P2).
- TIMEOUT_CYCLES, 0, cycles allowed per turn in S_WAIT before forfeit; 0 disables the turn timer.
- TIMER_W, 24, width of the turn timer; must be able to hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- new_game  input  1  synchronous clear to a fresh game; level, any state.
- move_valid  input  1  single-cycle move strobe.
- move_cell  input  4  target cell; 0..8 = A1,A2,A3,B1,B2,B3,C1,C2,C3.
- outcome  input  3  checker result: 0 in progress, 1 P1 win, 2 P1 lose, 3 tie.
- A1_val..C3_val  output  2 each  cell registers (nine ports): 00 empty, 01 P1, 10 P2.
- cur_player  output  2  player to move (01/10).
- move_count  output  4  legal moves placed, 0..9.
- game_over  output  1  high while in S_OVER.
- result  output  2  latched final outcome (0 while game in progress).
- move_rejected  output  1  one-cycle pulse on an illegal move.
- turn_timeout  output  1  one-cycle pulse on turn forfeit.

Behaviour:
- Reset (rst=0, async): all cells 00, cur_player=START_PLAYER, move_count=0, result=0, game_over=0, pulses 0, timer=0, state S_WAIT.
- States: S_WAIT, S_CHECK, S_OVER.
- new_game=1 at a clock edge: same values as reset, in any state. Has priority over move_valid and the timer.

S_WAIT:
- Legal move: move_valid=1, move_cell<=8 and target cell 00. At the next edge, write cur_player into the cell, increment move_count, go to S_CHECK, clear the timer. The write is visible on *_val the cycle after the strobe.
- Illegal move (cell occupied or move_cell>8): board, player and count unchanged. move_rejected=1 for exactly the next cycle. Stay in S_WAIT; the timer keeps running.
- Timer (TIMEOUT_CYCLES>0):
  - Increments each S_WAIT cycle without a legal move.
  - When it reaches TIMEOUT_CYCLES-1 with no legal move that cycle: at the next edge toggle cur_player, clear the timer, and pulse turn_timeout for one cycle. move_count is unchanged.
  - A legal move in the expiry cycle wins; no timeout is taken.

S_CHECK (exactly 1 cycle; the outcome input reflects the new board):
- At the edge: if outcome is 1, 2 or 3, latch result=outcome[1:0] and go to S_OVER.
- Else if move_count==9, latch result=3 (TIE) and go to S_OVER.
- Else toggle cur_player and go to S_WAIT.
- move_valid is ignored, with no reject pulse.
- Outcome codes 4..7 are treated as 0.

S_OVER:
- Board, result and cur_player are frozen; game_over=1.
- move_valid is ignored, with no reject pulse; the timer is held at 0.
- Only new_game or rst leaves this state.

Latency: strobe to cell visible = 1 cycle; strobe to game_over = 2 cycles; strobe to next accepted move = 2 cycles minimum.

Constraints:
- Cell writes are the only path that changes *_val.
- Never more than one cell is written per move.
- Cells are never overwritten.

Test Plan:
- Reset, then P1 moves cells 0,3,1,4,2 (alternating, strobes 3 cycles apart) → A1..A3=01, B1,B2=10; game_over=1 and result=1 two cycles after the cell-2 strobe; move_count=5.
- P1 at cell 4, then P2 at cell 4 → move_rejected pulses once, B2 stays 01, cur_player stays 10, move_count=1. Then move_cell=9 → rejected again.
- Nine-move draw sequence 0,1,2,4,3,5,7,6,8 with checker stubbed to 0 → result=3, game_over=1 after the 9th move, move_count=9.
- TIMEOUT_CYCLES=5, no moves → turn_timeout pulses at cycle 5, cur_player 01→10, move_count=0. A legal move in cycle 5 → no timeout and the cell is written.
- In S_OVER, pulse move_valid to an empty cell → no change and no reject. Then new_game=1 together with move_valid → board cleared, cur_player=START_PLAYER, move ignored.
- Assert rst low mid-S_CHECK → all outputs return to reset values immediately (asynchronously); after release, S_WAIT with an empty board.

Source files
------------

// File: rtl/game_board_ctrl.sv
// Tic-tac-toe board writer: takes player moves, fills the nine cell registers,
// alternates turns, samples the external outcome checker and latches game over.
module game_board_ctrl #(
   parameter logic [1:0]  START_PLAYER   = 2'b01,
   parameter int unsigned TIMEOUT_CYCLES = 0,
   parameter int unsigned TIMER_W        = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       new_game,
   input  logic       move_valid,
   input  logic [3:0] move_cell,
   input  logic [2:0] outcome,
   output logic [1:0] A1_val,
   output logic [1:0] A2_val,
   output logic [1:0] A3_val,
   output logic [1:0] B1_val,
   output logic [1:0] B2_val,
   output logic [1:0] B3_val,
   output logic [1:0] C1_val,
   output logic [1:0] C2_val,
   output logic [1:0] C3_val,
   output logic [1:0] cur_player,
   output logic [3:0] move_count,
   output logic       game_over,
   output logic [1:0] result,
   output logic       move_rejected,
   output logic       turn_timeout
);

   localparam int unsigned NCELLS     = 9;
   localparam int unsigned CELL_W     = 2;
   localparam int unsigned CNT_W      = 4;
   localparam logic [CNT_W-1:0] FULL_BOARD = CNT_W'(NCELLS);
   localparam bit          TIMER_EN   = (TIMEOUT_CYCLES > 0);
   localparam int unsigned TIMER_LAST = TIMER_EN ? (TIMEOUT_CYCLES - 1) : 0;
   localparam logic [CELL_W-1:0] RES_TIE = 2'd3;

   typedef enum logic [1:0] {
      S_WAIT  = 2'd0,
      S_CHECK = 2'd1,
      S_OVER  = 2'd2
   } state_e;

   state_e                       state_q, state_d;
   logic [NCELLS-1:0][CELL_W-1:0] cells_q, cells_d;
   logic [CELL_W-1:0]            cur_player_q, cur_player_d;
   logic [CNT_W-1:0]             move_count_q, move_count_d;
   logic                         game_over_q, game_over_d;
   logic [CELL_W-1:0]            result_q, result_d;
   logic                         move_rejected_q, move_rejected_d;
   logic                         turn_timeout_q, turn_timeout_d;
   logic [TIMER_W-1:0]           timer_q, timer_d;

   logic occupied;
   logic legal;
   logic expire;
   logic outcome_hit;

   // Target-cell occupancy; out-of-range cells never match so they read as free
   always_comb begin
      occupied = 1'b0;
      for (int unsigned i = 0; i < NCELLS; i++) begin
         if (move_cell == CNT_W'(i) && cells_q[i] != 2'b00) begin
            occupied = 1'b1;
         end
      end
   end

   assign legal       = (state_q == S_WAIT) && move_valid &&
                        (move_cell < CNT_W'(NCELLS)) && !occupied;
   assign expire      = TIMER_EN && (state_q == S_WAIT) && !legal &&
                        (timer_q == TIMER_W'(TIMER_LAST));
   assign outcome_hit = (outcome == 3'd1) || (outcome == 3'd2) || (outcome == 3'd3);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_WAIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (new_game) begin
         state_d = S_WAIT;
      end else begin
         unique case (state_q)
            S_WAIT:  if (legal) state_d = S_CHECK;
            S_CHECK: state_d = (outcome_hit || move_count_q == FULL_BOARD) ? S_OVER : S_WAIT;
            S_OVER:  state_d = S_OVER;
            default: state_d = S_WAIT;
         endcase
      end
   end

   // Board, turn, counter, timer and pulse updates
   always_comb begin
      cells_d         = cells_q;
      cur_player_d    = cur_player_q;
      move_count_d    = move_count_q;
      result_d        = result_q;
      timer_d         = timer_q;
      move_rejected_d = 1'b0;
      turn_timeout_d  = 1'b0;
      game_over_d     = (state_d == S_OVER);
      if (new_game) begin
         cells_d      = '0;
         cur_player_d = START_PLAYER;
         move_count_d = '0;
         result_d     = '0;
         timer_d      = '0;
      end else begin
         unique case (state_q)
            S_WAIT: begin
               if (legal) begin
                  for (int unsigned i = 0; i < NCELLS; i++) begin
                     if (move_cell == CNT_W'(i)) cells_d[i] = cur_player_q;
                  end
                  move_count_d = move_count_q + CNT_W'(1);
                  timer_d      = '0;
               end else begin
                  move_rejected_d = move_valid;
                  if (expire) begin
                     cur_player_d   = cur_player_q ^ 2'b11;
                     timer_d        = '0;
                     turn_timeout_d = 1'b1;
                  end else if (TIMER_EN) begin
                     timer_d = timer_q + TIMER_W'(1);
                  end
               end
            end
            S_CHECK: begin
               timer_d = '0;
               if (outcome_hit) begin
                  result_d = outcome[1:0];
               end else if (move_count_q == FULL_BOARD) begin
                  result_d = RES_TIE;
               end else begin
                  cur_player_d = cur_player_q ^ 2'b11;
               end
            end
            default: timer_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cells_q         <= '0;
         cur_player_q    <= START_PLAYER;
         move_count_q    <= '0;
         game_over_q     <= 1'b0;
         result_q        <= '0;
         move_rejected_q <= 1'b0;
         turn_timeout_q  <= 1'b0;
         timer_q         <= '0;
      end else begin
         cells_q         <= cells_d;
         cur_player_q    <= cur_player_d;
         move_count_q    <= move_count_d;
         game_over_q     <= game_over_d;
         result_q        <= result_d;
         move_rejected_q <= move_rejected_d;
         turn_timeout_q  <= turn_timeout_d;
         timer_q         <= timer_d;
      end
   end

   assign A1_val        = cells_q[0];
   assign A2_val        = cells_q[1];
   assign A3_val        = cells_q[2];
   assign B1_val        = cells_q[3];
   assign B2_val        = cells_q[4];
   assign B3_val        = cells_q[5];
   assign C1_val        = cells_q[6];
   assign C2_val        = cells_q[7];
   assign C3_val        = cells_q[8];
   assign cur_player    = cur_player_q;
   assign move_count    = move_count_q;
   assign game_over     = game_over_q;
   assign result        = result_q;
   assign move_rejected = move_rejected_q;
   assign turn_timeout  = turn_timeout_q;

endmodule

// File: tb/tb_game_board_ctrl.sv
// Scoreboard bench for game_board_ctrl: two instances (timer on, P1 first / timer off,
// P2 first) share stimulus; a game-rules model predicts every cycle's outputs.
module tb_game_board_ctrl;

   localparam int unsigned TMO = 5;

   typedef struct packed {
      logic [8:0][1:0] cells;
      logic [1:0]      player;
      logic [3:0]      count;
      logic            over;
      logic [1:0]      result;
      logic            rej;
      logic            tmo;
   } snap_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       new_game = 1'b0;
   logic       move_valid = 1'b0;
   logic [3:0] move_cell = 4'd0;
   logic [2:0] oc [2];

   wire [8:0][1:0] cv0, cv1;
   wire [1:0]      pl0, pl1, res0, res1;
   wire [3:0]      cnt0, cnt1;
   wire            ov0, ov1, rj0, rj1, to0, to1;
   snap_t          act0, act1;

   assign act0 = {cv0, pl0, cnt0, ov0, res0, rj0, to0};
   assign act1 = {cv1, pl1, cnt1, ov1, res1, rj1, to1};

   always #5 clk = ~clk;

   game_board_ctrl #(.START_PLAYER(2'b01), .TIMEOUT_CYCLES(TMO), .TIMER_W(24)) dut0 (
      .clk(clk), .rst(rst_n), .new_game(new_game), .move_valid(move_valid),
      .move_cell(move_cell), .outcome(oc[0]),
      .A1_val(cv0[0]), .A2_val(cv0[1]), .A3_val(cv0[2]),
      .B1_val(cv0[3]), .B2_val(cv0[4]), .B3_val(cv0[5]),
      .C1_val(cv0[6]), .C2_val(cv0[7]), .C3_val(cv0[8]),
      .cur_player(pl0), .move_count(cnt0), .game_over(ov0), .result(res0),
      .move_rejected(rj0), .turn_timeout(to0));

   game_board_ctrl #(.START_PLAYER(2'b10), .TIMEOUT_CYCLES(0), .TIMER_W(8)) dut1 (
      .clk(clk), .rst(rst_n), .new_game(new_game), .move_valid(move_valid),
      .move_cell(move_cell), .outcome(oc[1]),
      .A1_val(cv1[0]), .A2_val(cv1[1]), .A3_val(cv1[2]),
      .B1_val(cv1[3]), .B2_val(cv1[4]), .B3_val(cv1[5]),
      .C1_val(cv1[6]), .C2_val(cv1[7]), .C3_val(cv1[8]),
      .cur_player(pl1), .move_count(cnt1), .game_over(ov1), .result(res1),
      .move_rejected(rj1), .turn_timeout(to1));

   // Game-rules model: board contents plus "a move is awaiting judgement" and idle-cycle count
   snap_t      m_s [2];
   bit         m_pend [2];
   int         m_wait [2];
   int         m_tmo [2]   = '{TMO, 0};
   logic [1:0] m_start [2] = '{2'b01, 2'b10};
   int         oc_mode [2] = '{0, 0};   // 0 real checker, 1 stubbed to 0, 2 junk codes 4..7

   int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
   int win_seq [5]  = '{0, 3, 1, 4, 2};
   int draw_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

   snap_t q0 [$];
   snap_t q1 [$];
   int    n_tests = 0;
   int    n_fail  = 0;

   function automatic logic [2:0] judge(input logic [8:0][1:0] b);
      int filled = 0;
      for (int l = 0; l < 8; l++) begin
         if (b[lines[l][0]] != 2'b00 && b[lines[l][0]] == b[lines[l][1]] &&
             b[lines[l][0]] == b[lines[l][2]])
            return (b[lines[l][0]] == 2'b01) ? 3'd1 : 3'd2;
      end
      for (int i = 0; i < 9; i++) if (b[i] != 2'b00) filled++;
      return (filled == 9) ? 3'd3 : 3'd0;
   endfunction

   function automatic logic [2:0] drive_oc(input int k);
      logic [2:0] j;
      j = judge(m_s[k].cells);
      if (oc_mode[k] == 1) return 3'd0;
      if (oc_mode[k] == 2 && j == 3'd0) return 3'(4 + $urandom_range(0, 3));
      return j;
   endfunction

   function automatic void mreset(input int k);
      m_s[k]        = '0;
      m_s[k].player = m_start[k];
      m_pend[k]     = 1'b0;
      m_wait[k]     = 0;
   endfunction

   function automatic void step(input int k, input bit ng, input bit mv,
                                input logic [3:0] mc, input logic [2:0] o);
      bit legal;
      m_s[k].rej = 1'b0;
      m_s[k].tmo = 1'b0;
      if (ng) begin
         mreset(k);
         return;
      end
      if (m_s[k].over) return;
      if (m_pend[k]) begin
         m_pend[k] = 1'b0;
         if (o >= 3'd1 && o <= 3'd3) begin
            m_s[k].over = 1'b1;  m_s[k].result = o[1:0];
         end else if (m_s[k].count == 4'd9) begin
            m_s[k].over = 1'b1;  m_s[k].result = 2'd3;
         end else begin
            m_s[k].player = (m_s[k].player == 2'b01) ? 2'b10 : 2'b01;
         end
         return;
      end
      legal = 1'b0;
      if (mv && mc <= 4'd8) legal = (m_s[k].cells[mc] == 2'b00);
      if (legal) begin
         m_s[k].cells[mc] = m_s[k].player;
         m_s[k].count++;
         m_pend[k] = 1'b1;
         m_wait[k] = 0;
      end else begin
         m_s[k].rej = mv;
         if (m_tmo[k] > 0) begin
            m_wait[k]++;
            if (m_wait[k] == m_tmo[k]) begin
               m_s[k].player = (m_s[k].player == 2'b01) ? 2'b10 : 2'b01;
               m_s[k].tmo    = 1'b1;
               m_wait[k]     = 0;
            end
         end
      end
   endfunction

   task automatic cmp_snap(input string nm, input int k, input snap_t a, input snap_t e);
      n_tests++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s[%0d] t=%0t: got cells=%h pl=%b cnt=%0d over=%b res=%0d rej=%b tmo=%b; want cells=%h pl=%b cnt=%0d over=%b res=%0d rej=%b tmo=%b",
                  nm, k, $time, a.cells, a.player, a.count, a.over, a.result, a.rej, a.tmo,
                  e.cells, e.player, e.count, e.over, e.result, e.rej, e.tmo);
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_tests++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s t=%0t: got %0h, want %0h", nm, $time, a, e);
      end
   endtask

   // Apply one cycle of inputs now and queue the predicted post-edge outputs
   task automatic drive(input bit ng, input bit mv, input logic [3:0] mc);
      new_game   = ng;
      move_valid = mv;
      move_cell  = mc;
      for (int k = 0; k < 2; k++) begin
         oc[k] = drive_oc(k);
         step(k, ng, mv, mc, oc[k]);
      end
      q0.push_back(m_s[0]);
      q1.push_back(m_s[1]);
   endtask

   task automatic cyc(input bit ng, input bit mv, input logic [3:0] mc);
      @(negedge clk);
      drive(ng, mv, mc);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'b0, 4'd0);
   endtask

   // Monitor: every cycle the DUTs present a full output snapshot
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (q0.size() > 0) cmp_snap("cycle", 0, act0, q0.pop_front());
         if (q1.size() > 0) cmp_snap("cycle", 1, act1, q1.pop_front());
      end
   end

   initial begin
      oc[0] = 3'd0;
      oc[1] = 3'd0;
      mreset(0);
      mreset(1);
      repeat (2) @(negedge clk);
      cmp_snap("reset", 0, act0, m_s[0]);
      cmp_snap("reset", 1, act1, m_s[1]);
      chk("reset_player1", 32'(pl1), 32'h2);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 4'd0);

      // Row A win for the first player
      cyc(1'b1, 1'b0, 4'd0);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b1, 4'(win_seq[i]));
         idle(2);
      end
      chk("win_result0", 32'(res0), 32'd1);
      chk("win_over0", 32'(ov0), 32'd1);
      chk("win_count0", 32'(cnt0), 32'd5);
      chk("win_rowA0", 32'({cv0[0], cv0[1], cv0[2]}), 32'h15);
      chk("win_B1B2_0", 32'({cv0[3], cv0[4]}), 32'ha);
      chk("win_result1", 32'(res1), 32'd2);

      // Moves in game-over are ignored silently; new_game beats a simultaneous move
      cyc(1'b0, 1'b1, 4'd8);
      idle(1);
      chk("over_norej", 32'(rj0), 32'd0);
      chk("over_cell8", 32'(cv0[8]), 32'd0);
      cyc(1'b1, 1'b1, 4'd5);
      idle(1);
      chk("ng_board", 32'(cv0), 32'd0);
      chk("ng_player", 32'(pl0), 32'd1);
      chk("ng_over", 32'(ov0), 32'd0);

      // Occupied cell and out-of-range cell are rejected
      cyc(1'b1, 1'b0, 4'd0);
      cyc(1'b0, 1'b1, 4'd4);
      idle(2);
      cyc(1'b0, 1'b1, 4'd4);
      idle(1);
      chk("rej_occupied", 32'(rj0), 32'd1);
      chk("rej_B2", 32'(cv0[4]), 32'd1);
      chk("rej_player", 32'(pl0), 32'd2);
      chk("rej_count", 32'(cnt0), 32'd1);
      cyc(1'b0, 1'b1, 4'd9);
      idle(1);
      chk("rej_range", 32'(rj0), 32'd1);

      // Nine-move draw with the checker stubbed to 0
      oc_mode = '{1, 1};
      cyc(1'b1, 1'b0, 4'd0);
      for (int i = 0; i < 9; i++) begin
         cyc(1'b0, 1'b1, 4'(draw_seq[i]));
         idle(1);
      end
      idle(1);
      chk("draw_result", 32'(res0), 32'd3);
      chk("draw_over", 32'(ov0), 32'd1);
      chk("draw_count", 32'(cnt0), 32'd9);
      oc_mode = '{0, 0};

      // Turn timer expiry with no moves
      cyc(1'b1, 1'b0, 4'd0);
      idle(5);
      chk("tmo_early", 32'(to0), 32'd0);
      idle(1);
      chk("tmo_pulse", 32'(to0), 32'd1);
      chk("tmo_player", 32'(pl0), 32'd2);
      chk("tmo_count", 32'(cnt0), 32'd0);
      idle(1);
      chk("tmo_oneshot", 32'(to0), 32'd0);

      // A legal move in the expiry cycle beats the timeout
      cyc(1'b1, 1'b0, 4'd0);
      idle(4);
      cyc(1'b0, 1'b1, 4'd4);
      idle(1);
      chk("tmo_race_pulse", 32'(to0), 32'd0);
      chk("tmo_race_cell", 32'(cv0[4]), 32'd1);

      // Asynchronous reset while judging a move
      cyc(1'b1, 1'b0, 4'd0);
      cyc(1'b0, 1'b1, 4'd0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      mreset(0);
      mreset(1);
      cmp_snap("async_rst", 0, act0, m_s[0]);
      cmp_snap("async_rst", 1, act1, m_s[1]);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 4'd0);
      idle(1);
      chk("post_rst_board", 32'(cv0), 32'd0);

      // Randomized play
      for (int n = 0; n < 3000; n++) begin
         bit ng;
         ng = ($urandom_range(0, 99) < 2);
         if (ng) oc_mode = '{int'($urandom_range(0, 2)), int'($urandom_range(0, 2))};
         cyc(ng, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 10)));
      end
      idle(1);
      @(posedge clk);
      #3;
      chk("drain", 32'(q0.size() + q1.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
